// File: rtl/stage2_pool_stream_core_pkg.sv
// stage2_pool_stream_core_pkg: shared geometry, derived widths and mode encoding
// for the stage-2 streaming pooling core.
package stage2_pool_stream_core_pkg;
    localparam int ST2_Pool_CI  = 3;
    localparam int ST2_Pool_IBW = 19;
    localparam int ST2_Pool_IW  = 12;
    localparam int ST2_Pool_IH  = 12;
    localparam int ST2_Pool_K   = 2;
    localparam int LOG2K        = $clog2(ST2_Pool_K);
    localparam int ACC_W        = ST2_Pool_IBW + 2 * LOG2K;
    typedef enum logic {POOL_MODE_MAX = 1'b0, POOL_MODE_AVG = 1'b1} pool_mode_e;
endpackage

// File: rtl/stage2_pool_stream_core_window_ch.sv
// stage2_pool_window_ch: one channel's row of window partials, the max/sum
// combine, and the registered final select (average = floor via arithmetic shift).
module stage2_pool_window_ch
    import stage2_pool_stream_core_pkg::*;
#(
    parameter int IBW = ST2_Pool_IBW,
    parameter int IW  = ST2_Pool_IW,
    parameter int K   = ST2_Pool_K,
    parameter int WCW = $clog2(ST2_Pool_IW) - $clog2(ST2_Pool_K)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic           first,
    input  logic           last,
    input  pool_mode_e     mode,
    input  logic [WCW-1:0] wc,
    input  logic [IBW-1:0] x,
    output logic [IBW-1:0] result
);
    localparam int SH = 2 * $clog2(K);
    localparam int AW = IBW + SH;

    logic signed [AW-1:0]  partial [IW/K];
    logic signed [AW-1:0]  xe, cur, comb;
    logic signed [IBW-1:0] avg;

    always_comb begin
        xe   = {{SH{x[IBW-1]}}, x};
        cur  = partial[wc];
        comb = first ? xe : mode == POOL_MODE_AVG ? cur + xe : (cur > xe ? cur : xe);
        avg  = IBW'(comb >>> SH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < IW/K; i++) partial[i] <= '0;
            result <= '0;
        end else if (en) begin
            partial[wc] <= comb;
            if (last) result <= mode == POOL_MODE_AVG ? avg : comb[IBW-1:0];
        end
    end
endmodule

// File: rtl/stage2_pool_stream_core.sv
// stage2_pool_stream_core: streaming CI-lane KxK/stride-K max/average pooling;
// owns raster counters, per-frame mode latch, window decode and output strobes.
module stage2_pool_stream_core
    import stage2_pool_stream_core_pkg::*;
#(
    parameter int CI  = ST2_Pool_CI,
    parameter int IBW = ST2_Pool_IBW,
    parameter int IW  = ST2_Pool_IW,
    parameter int IH  = ST2_Pool_IH,
    parameter int K   = ST2_Pool_K
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_in_valid,
    input  logic              i_sof,
    input  logic              i_mode,
    input  logic [CI*IBW-1:0] i_in_fmap,
    output logic              o_ot_valid,
    output logic [CI*IBW-1:0] o_ot_fmap,
    output logic              o_frame_done
);
    localparam int LK  = $clog2(K);
    localparam int CW  = $clog2(IW);
    localparam int RW  = $clog2(IH);
    localparam int WCW = CW - LK;

    logic [CW-1:0] col, pc;
    logic [RW-1:0] row, pr;
    pool_mode_e    mode_q, mode;
    logic          frame_first, first, last, frame_last;

    // i_sof overrides the counters so the pixel is always treated as (0,0)
    always_comb begin
        pc          = i_sof ? '0 : col;
        pr          = i_sof ? '0 : row;
        frame_first = i_sof || (row == '0 && col == '0);
        mode        = frame_first ? pool_mode_e'(i_mode) : mode_q;
        first       = pr[LK-1:0] == '0 && pc[LK-1:0] == '0;
        last        = &pr[LK-1:0] && &pc[LK-1:0];
        frame_last  = pr == RW'(IH-1) && pc == CW'(IW-1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col          <= '0;
            row          <= '0;
            mode_q       <= POOL_MODE_MAX;
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_ot_valid   <= i_in_valid && last;
            o_frame_done <= i_in_valid && frame_last;
            if (i_in_valid) begin
                mode_q <= mode;
                col    <= pc == CW'(IW-1) ? '0 : pc + 1'b1;
                row    <= pc == CW'(IW-1) ? (pr == RW'(IH-1) ? '0 : pr + 1'b1) : pr;
            end
        end
    end

    for (genvar c = 0; c < CI; c++) begin : g_ch
        stage2_pool_window_ch #(.IBW(IBW), .IW(IW), .K(K), .WCW(WCW)) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (i_in_valid),
            .first  (first),
            .last   (last),
            .mode   (mode),
            .wc     (pc[CW-1:LK]),
            .x      (i_in_fmap[c*IBW +: IBW]),
            .result (o_ot_fmap[c*IBW +: IBW])
        );
    end
endmodule

// File: tb/tb_stage2_pool_stream_core.sv
// tb_stage2_pool_stream_core: randomized scenarios checked against a window-array
// reference model plus fixed expected ramp results.
module tb_stage2_pool_stream_core;
    localparam int CI = 3, IBW = 19, IW = 4, IH = 4, K = 2;
    localparam int FW = CI * IBW;

    logic          clk = 0, reset_n = 0, i_in_valid = 0, i_sof = 0, i_mode = 0;
    logic [FW-1:0] i_in_fmap = '0;
    logic          o_ot_valid, o_frame_done;
    logic [FW-1:0] o_ot_fmap;

    int n_cmp = 0, n_bad = 0;

    int            pix [IH][IW][CI];
    int            mr, mc;
    logic          mm, ev, ed;
    logic [FW-1:0] ef, hold;

    stage2_pool_stream_core #(.CI(CI), .IBW(IBW), .IW(IW), .IH(IH), .K(K)) dut (
        .clk(clk), .reset_n(reset_n), .i_in_valid(i_in_valid), .i_sof(i_sof),
        .i_mode(i_mode), .i_in_fmap(i_in_fmap), .o_ot_valid(o_ot_valid),
        .o_ot_fmap(o_ot_fmap), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mr = 0; mc = 0; mm = 0; hold = '0; ev = 0; ed = 0; ef = '0;
    endtask

    // Stores each pixel at its raster position; a completed window is pooled from the stored pixels.
    task automatic model(input logic v, input logic s, input logic m, input logic [FW-1:0] d);
        int best, sum, q;
        ev = 0; ed = 0;
        if (v) begin
            if (s) begin mr = 0; mc = 0; end
            if (mr == 0 && mc == 0) mm = m;
            for (int ch = 0; ch < CI; ch++) pix[mr][mc][ch] = int'($signed(d[ch*IBW +: IBW]));
            if (mr % K == K-1 && mc % K == K-1) begin
                for (int ch = 0; ch < CI; ch++) begin
                    best = pix[mr][mc][ch]; sum = 0;
                    for (int r = mr-K+1; r <= mr; r++)
                        for (int c = mc-K+1; c <= mc; c++) begin
                            sum += pix[r][c][ch];
                            if (pix[r][c][ch] > best) best = pix[r][c][ch];
                        end
                    q = sum / (K*K);
                    if (sum < 0 && sum % (K*K) != 0) q -= 1;
                    hold[ch*IBW +: IBW] = IBW'(mm ? q : best);
                end
                ev = 1;
                ed = (mr == IH-1 && mc == IW-1);
            end
            mc++;
            if (mc == IW) begin mc = 0; mr = (mr + 1) % IH; end
        end
        ef = hold;
    endtask

    task automatic cyc(input logic v, input logic s, input logic m, input logic [FW-1:0] d);
        i_in_valid = v; i_sof = s; i_mode = m; i_in_fmap = d;
        model(v, s, m, d);
        @(posedge clk); #1;
        i_in_valid = 0; i_sof = 0;
    endtask

    function automatic logic [FW-1:0] mkpix(input int v0);
        mkpix = {IBW'($urandom), IBW'($urandom_range(0, 2000) - 1000), IBW'(v0)};
    endfunction

    task automatic test_reset();
        n_cmp++; if (o_ot_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_ot_valid); end
        n_cmp++; if (o_frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", o_frame_done); end
        n_cmp++; if (o_ot_fmap !== '0) begin n_bad++; $display("FAIL reset_fmap: got %h want 0", o_ot_fmap); end
    endtask

    task automatic test_max();
        int vals[$];
        for (int i = 0; i < 16; i++) begin
            cyc(1, i == 0, 0, mkpix(i + 1));
            n_cmp++;
            if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {ev, ed, ef}) begin
                n_bad++; $display("FAIL max px%0d: got v=%b d=%b f=%h want v=%b d=%b f=%h", i, o_ot_valid, o_frame_done, o_ot_fmap, ev, ed, ef);
            end
            if (o_ot_valid) vals.push_back(int'($signed(o_ot_fmap[IBW-1:0])));
        end
        n_cmp++;
        if (vals.size() != 4 || vals[0] != 6 || vals[1] != 8 || vals[2] != 14 || vals[3] != 16) begin
            n_bad++; $display("FAIL max_ramp: got %p want '{6,8,14,16}", vals);
        end
    endtask

    task automatic test_avg();
        int vals[$];
        for (int i = 0; i < 16; i++) begin
            cyc(1, i == 0, 1, mkpix(i + 1));
            n_cmp++;
            if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {ev, ed, ef}) begin
                n_bad++; $display("FAIL avg px%0d: got v=%b d=%b f=%h want v=%b d=%b f=%h", i, o_ot_valid, o_frame_done, o_ot_fmap, ev, ed, ef);
            end
            if (o_ot_valid) vals.push_back(int'($signed(o_ot_fmap[IBW-1:0])));
        end
        n_cmp++;
        if (vals.size() != 4 || vals[0] != 3 || vals[1] != 5 || vals[2] != 11 || vals[3] != 13) begin
            n_bad++; $display("FAIL avg_ramp: got %p want '{3,5,11,13}", vals);
        end
    endtask

    task automatic test_signed();
        int neg [4] = '{-1, -2, -3, -4};
        int want [2] = '{-1, -3};
        int vals[$];
        for (int f = 0; f < 2; f++) begin
            vals.delete();
            for (int i = 0; i < 16; i++) begin
                int idx;
                idx = (i / IW) * 2 + (i % IW);
                cyc(1, i == 0, logic'(f), mkpix((i % IW) < 2 && i < 2*IW ? neg[idx] : int'($urandom_range(0, 600)) - 300));
                n_cmp++;
                if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {ev, ed, ef}) begin
                    n_bad++; $display("FAIL signed f%0d px%0d: got v=%b d=%b f=%h want v=%b d=%b f=%h", f, i, o_ot_valid, o_frame_done, o_ot_fmap, ev, ed, ef);
                end
                if (o_ot_valid) vals.push_back(int'($signed(o_ot_fmap[IBW-1:0])));
            end
            n_cmp++;
            if (vals.size() != 4 || vals[0] != want[f]) begin
                n_bad++; $display("FAIL signed_win0 f%0d: got %p want first %0d", f, vals, want[f]);
            end
        end
    endtask

    task automatic test_gaps();
        int vals[$];
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) begin
                cyc(0, 0, 0, mkpix(99));
                n_cmp++;
                if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {ev, ed, ef}) begin
                    n_bad++; $display("FAIL gap_idle px%0d: got v=%b d=%b f=%h want v=%b d=%b f=%h", i, o_ot_valid, o_frame_done, o_ot_fmap, ev, ed, ef);
                end
            end
            cyc(1, i == 0, 0, mkpix(i + 1));
            n_cmp++;
            if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {ev, ed, ef}) begin
                n_bad++; $display("FAIL gap px%0d: got v=%b d=%b f=%h want v=%b d=%b f=%h", i, o_ot_valid, o_frame_done, o_ot_fmap, ev, ed, ef);
            end
            if (o_ot_valid) vals.push_back(int'($signed(o_ot_fmap[IBW-1:0])));
        end
        n_cmp++;
        if (vals.size() != 4 || vals[0] != 6 || vals[1] != 8 || vals[2] != 14 || vals[3] != 16) begin
            n_bad++; $display("FAIL gap_ramp: got %p want '{6,8,14,16}", vals);
        end
    endtask

    task automatic test_mode_change();
        int vals[$];
        for (int f = 0; f < 2; f++) begin
            vals.delete();
            for (int i = 0; i < 16; i++) begin
                cyc(1, i == 0, f == 0 ? (i < 5) : (i != 0), mkpix(i + 1));
                n_cmp++;
                if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {ev, ed, ef}) begin
                    n_bad++; $display("FAIL mode f%0d px%0d: got v=%b d=%b f=%h want v=%b d=%b f=%h", f, i, o_ot_valid, o_frame_done, o_ot_fmap, ev, ed, ef);
                end
                if (o_ot_valid) vals.push_back(int'($signed(o_ot_fmap[IBW-1:0])));
            end
            n_cmp++;
            if (vals.size() != 4 || vals[0] != (f == 0 ? 3 : 6) || vals[3] != (f == 0 ? 13 : 16)) begin
                n_bad++; $display("FAIL mode_frame%0d: got %p want %s", f, vals, f == 0 ? "avg 3..13" : "max 6..16");
            end
        end
    endtask

    task automatic test_resync();
        int vals[$];
        for (int i = 0; i < 6; i++) begin
            cyc(1, i == 0, 1, mkpix(int'($urandom_range(0, 500))));
            n_cmp++;
            if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {ev, ed, ef}) begin
                n_bad++; $display("FAIL resync_pre px%0d: got v=%b d=%b f=%h want v=%b d=%b f=%h", i, o_ot_valid, o_frame_done, o_ot_fmap, ev, ed, ef);
            end
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1, i == 0, 0, mkpix(i + 1));
            n_cmp++;
            if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {ev, ed, ef}) begin
                n_bad++; $display("FAIL resync px%0d: got v=%b d=%b f=%h want v=%b d=%b f=%h", i, o_ot_valid, o_frame_done, o_ot_fmap, ev, ed, ef);
            end
            if (o_ot_valid) vals.push_back(int'($signed(o_ot_fmap[IBW-1:0])));
        end
        n_cmp++;
        if (vals.size() != 4 || vals[0] != 6 || vals[1] != 8 || vals[2] != 14 || vals[3] != 16) begin
            n_bad++; $display("FAIL resync_ramp: got %p want '{6,8,14,16}", vals);
        end
    endtask

    task automatic test_reset_mid();
        int vals[$];
        for (int i = 0; i < 6; i++) cyc(1, i == 0, 0, mkpix(i + 1));
        reset_n = 0; #1;
        n_cmp++;
        if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {1'b0, 1'b0, FW'(0)}) begin
            n_bad++; $display("FAIL reset_mid: got v=%b d=%b f=%h want all zero", o_ot_valid, o_frame_done, o_ot_fmap);
        end
        @(negedge clk); reset_n = 1; model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 1, mkpix(i + 1));
            n_cmp++;
            if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {ev, ed, ef}) begin
                n_bad++; $display("FAIL post_reset px%0d: got v=%b d=%b f=%h want v=%b d=%b f=%h", i, o_ot_valid, o_frame_done, o_ot_fmap, ev, ed, ef);
            end
            if (o_ot_valid) vals.push_back(int'($signed(o_ot_fmap[IBW-1:0])));
        end
        n_cmp++;
        if (vals.size() != 4 || vals[0] != 3 || vals[1] != 5 || vals[2] != 11 || vals[3] != 13) begin
            n_bad++; $display("FAIL post_reset_ramp: got %p want '{3,5,11,13}", vals);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1, 0, logic'($urandom_range(0, 1)), mkpix(int'($urandom_range(0, 4000)) - 2000));
            n_cmp++;
            if ({o_ot_valid, o_frame_done, o_ot_fmap} !== {ev, ed, ef}) begin
                n_bad++; $display("FAIL b2b px%0d: got v=%b d=%b f=%h want v=%b d=%b f=%h", i, o_ot_valid, o_frame_done, o_ot_fmap, ev, ed, ef);
            end
            if (o_frame_done) dones++;
        end
        n_cmp++;
        if (dones != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); reset_n = 1;
        @(posedge clk); #1;
        test_max();
        test_avg();
        test_signed();
        test_gaps();
        test_mode_change();
        test_resync();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
